frame_row_sequencer: RTL

FRAME_ROW_SEQUENCER -- requirements
Module: frame_row_sequencer

---
 rtl/frame_row_sequencer_pkg.sv | 19 +
 rtl/frame_row_sequencer_strobe_decode.sv | 24 ++
 rtl/frame_row_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/frame_row_sequencer_pkg.sv
// Shared definitions for the frame row sequencer: state encoding, the
// header magic byte and the bit positions of the header fields.
package frame_row_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_STROBE = 2'd3
  } seq_state_t;

  localparam logic [7:0] HDR_MAGIC     = 8'hFD;
  localparam int         HDR_MAGIC_MSB = 31;
  localparam int         HDR_MAGIC_LSB = 24;
  localparam int         HDR_INDEX_MSB = 4;
  localparam int         HDR_INDEX_LSB = 0;
  localparam int         FRAME_INDEX_W = HDR_INDEX_MSB - HDR_INDEX_LSB + 1;

endpackage

// File: rtl/frame_row_sequencer_strobe_decode.sv
// Frame strobe decoder: turns a frame index plus enable into a one-hot
// write strobe. Indices at or beyond MaxFramesPerCol produce all zeros.
module frame_strobe_decode
  import frame_row_sequencer_pkg::*;
#(
  parameter int IndexWidth      = FRAME_INDEX_W,
  parameter int MaxFramesPerCol = 20
) (
  input  logic [IndexWidth-1:0]      frame_idx,
  input  logic                       en,
  output logic [MaxFramesPerCol-1:0] strobe
);

  // One-hot decode; an out-of-range index matches no bit.
  always_comb begin
    strobe = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      if (en && (32'(frame_idx) == 32'(i))) begin
        strobe[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_row_sequencer.sv
// Frame row sequencer: accepts a header word followed by one word per row,
// broadcasts each word with a one-cycle row select, then issues a one-hot
// frame strobe once all rows are written.
// Optional feature macro: FRAME_SEQ_CHECKSUM_EN adds a CHECK state that
// takes one extra word and compares it with the XOR of the row words.
module frame_row_sequencer
  import frame_row_sequencer_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int RowSelectWidth  = 5,
  parameter int NumberOfRows    = 6,
  parameter int MaxFramesPerCol = 20
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [FrameBitsPerRow-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  output logic [RowSelectWidth-1:0]  RowSelect_O,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam logic [RowSelectWidth-1:0] LAST_ROW = RowSelectWidth'(NumberOfRows);

  seq_state_t                 state_q, state_d;
  logic [RowSelectWidth-1:0]  row_cnt_q;
  logic [FRAME_INDEX_W-1:0]   frame_idx_q;
  logic                       frame_ok_q;
  logic                       err_q;
  logic [FrameBitsPerRow-1:0] frame_data_p1;
  logic [RowSelectWidth-1:0]  row_sel_p1;
  logic                       ready_c;
  logic                       take;
  logic                       hdr_seen;
  logic                       hdr_idx_ok;
  logic [FRAME_INDEX_W-1:0]   hdr_idx;
  logic                       strobe_en;
`ifdef FRAME_SEQ_CHECKSUM_EN
  logic [FrameBitsPerRow-1:0] csum_q;
`endif

  assign hdr_idx    = s_data[HDR_INDEX_MSB:HDR_INDEX_LSB];
  assign hdr_seen   = (s_data[HDR_MAGIC_MSB:HDR_MAGIC_LSB] == HDR_MAGIC);
  assign hdr_idx_ok = (32'(hdr_idx) < 32'(MaxFramesPerCol));
  assign take       = s_valid && ready_c;
  // Ready is forced low while reset is held, even though state already reads IDLE.
  assign s_ready    = ready_c && !RST;
  assign busy_o     = (state_q != ST_IDLE);
  assign err_o      = err_q;
  assign FrameData_O = frame_data_p1;
  assign RowSelect_O = row_sel_p1;
  assign strobe_en   = (state_q == ST_STROBE) && frame_ok_q;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and ready. After the last row is accepted the row counter
  // sits one past the end for a drain cycle, so the last row select is seen
  // before the strobe.
  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (s_valid && hdr_seen) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ready_c = (row_cnt_q <= LAST_ROW);
        if (row_cnt_q > LAST_ROW) begin
`ifdef FRAME_SEQ_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_STROBE;
`endif
        end
      end
`ifdef FRAME_SEQ_CHECKSUM_EN
      ST_CHECK: begin
        ready_c = 1'b1;
        if (s_valid) begin
          state_d = ST_STROBE;
        end
      end
`endif
      ST_STROBE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Frame bookkeeping: row counter, frame index/validity, sticky error, checksum.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_cnt_q   <= '0;
      frame_idx_q <= '0;
      frame_ok_q  <= 1'b0;
      err_q       <= 1'b0;
`ifdef FRAME_SEQ_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (take && hdr_seen) begin
            row_cnt_q   <= RowSelectWidth'(1);
            frame_idx_q <= hdr_idx;
            frame_ok_q  <= hdr_idx_ok;
            if (!hdr_idx_ok) begin
              err_q <= 1'b1;
            end
`ifdef FRAME_SEQ_CHECKSUM_EN
            csum_q <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (take) begin
            row_cnt_q <= row_cnt_q + 1'b1;
`ifdef FRAME_SEQ_CHECKSUM_EN
            csum_q <= csum_q ^ s_data;
`endif
          end
        end
`ifdef FRAME_SEQ_CHECKSUM_EN
        ST_CHECK: begin
          if (take && (s_data != csum_q)) begin
            err_q      <= 1'b1;
            frame_ok_q <= 1'b0;
          end
        end
`endif
        ST_STROBE: row_cnt_q <= '0;
        default: ;
      endcase
    end
  end

  // ---- stage p1: registered row broadcast (data holds, select pulses) ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_data_p1 <= '0;
      row_sel_p1    <= '0;
    end else begin
      row_sel_p1 <= '0;
      if (take && (state_q == ST_LOAD)) begin
        frame_data_p1 <= s_data;
        row_sel_p1    <= row_cnt_q;
      end
    end
  end

  frame_strobe_decode #(
    .IndexWidth      (FRAME_INDEX_W),
    .MaxFramesPerCol (MaxFramesPerCol)
  ) u_strobe_decode (
    .frame_idx (frame_idx_q),
    .en        (strobe_en),
    .strobe    (FrameStrobe_O)
  );

endmodule
